// File: rtl/sobel_row_registers.sv
// rtl/sobel_row_registers.sv - 3-row sliding window feeding the Sobel core
// Row words shift in from the memory read path; one strip of IMG_ROWS rows per start.
module sobel_row_registers #(
  parameter int NUM_ACCEL = 4,
  parameter int DATA_W    = (NUM_ACCEL + 2) * 8,
  parameter int IMG_ROWS  = 16,
  parameter int WCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl2srow_start,
  input  logic [DATA_W-1:0] mem2srow_read_data,
  input  logic              mem2srow_read_valid,
  output logic              srow2mem_read_ready,
  output logic [DATA_W-1:0] srow2sacc_row1_data,
  output logic [DATA_W-1:0] srow2sacc_row2_data,
  output logic [DATA_W-1:0] srow2sacc_row3_data,
  output logic              srow2sacc_valid,
  input  logic              sacc2srow_ready,
  output logic              srow2ctrl_strip_done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD, S_DONE} state_t;

  localparam logic [WCNT_W-1:0] LAST_WIN = WCNT_W'(IMG_ROWS - 3);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_row1;
  logic [DATA_W-1:0] r_row2;
  logic [DATA_W-1:0] r_row3;
  logic [1:0]        r_rows_loaded;
  logic [WCNT_W-1:0] r_win_cnt;
  logic              w_accept;
  logic              w_last;
  logic              w_clear;
  logic              w_win_inc;

  assign w_last   = (r_win_cnt == LAST_WIN);
  assign w_accept = mem2srow_read_valid & srow2mem_read_ready;

  // Handshake terms are rebuilt from inputs here so the ready output never feeds back into this block.
  always_comb begin
    w_next               = r_state;
    srow2mem_read_ready  = 1'b0;
    srow2sacc_valid      = 1'b0;
    srow2ctrl_strip_done = 1'b0;
    w_clear              = 1'b0;
    w_win_inc            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl2srow_start) begin
          w_clear = 1'b1;
          w_next  = S_FILL;
        end
      end
      S_FILL: begin
        srow2mem_read_ready = 1'b1;
        if (mem2srow_read_valid && (r_rows_loaded >= 2'd2)) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        srow2sacc_valid     = 1'b1;
        srow2mem_read_ready = sacc2srow_ready & ~w_last;
        if (sacc2srow_ready) begin
          if (w_last) begin
            w_next = S_DONE;
          end else begin
            w_win_inc = 1'b1;
            w_next    = mem2srow_read_valid ? S_HOLD : S_FILL;
          end
        end
      end
      S_DONE: begin
        srow2ctrl_strip_done = 1'b1;
        w_next               = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_row1        <= '0;
      r_row2        <= '0;
      r_row3        <= '0;
      r_rows_loaded <= 2'd0;
      r_win_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_row1 <= r_row2;
        r_row2 <= r_row3;
        r_row3 <= mem2srow_read_data;
        if (r_rows_loaded != 2'd3) begin
          r_rows_loaded <= r_rows_loaded + 2'd1;
        end
      end
      if (w_clear) begin
        r_rows_loaded <= 2'd0;
        r_win_cnt     <= '0;
      end else if (w_win_inc) begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end
    end
  end

  assign srow2sacc_row1_data = r_row1;
  assign srow2sacc_row2_data = r_row2;
  assign srow2sacc_row3_data = r_row3;

endmodule

// File: tb/tb_sobel_row_registers.sv
// tb/tb_sobel_row_registers.sv - scoreboard bench for sobel_row_registers
// Directed strips push expected windows; a monitor pops them on every consume.
module tb_sobel_row_registers;

  localparam int NACC = 4;
  localparam int DW   = (NACC + 2) * 8;
  localparam int IMG  = 4;

  typedef struct {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] r3;
  } win_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] row1;
  logic [DW-1:0] row2;
  logic [DW-1:0] row3;
  logic          valid;
  logic          sacc_ready;
  logic          done;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_acc  = 0;
  int   n_cons = 0;
  int   n_done = 0;
  win_t exp_q[$];
  win_t mon_e;
  bit   hold_prev = 0;
  logic [3*DW-1:0] held;

  sobel_row_registers #(
    .NUM_ACCEL(NACC),
    .DATA_W   (DW),
    .IMG_ROWS (IMG),
    .WCNT_W   (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ctrl2srow_start     (start),
    .mem2srow_read_data  (rd_data),
    .mem2srow_read_valid (rd_valid),
    .srow2mem_read_ready (rd_ready),
    .srow2sacc_row1_data (row1),
    .srow2sacc_row2_data (row2),
    .srow2sacc_row3_data (row3),
    .srow2sacc_valid     (valid),
    .sacc2srow_ready     (sacc_ready),
    .srow2ctrl_strip_done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rw(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [DW-1:0] a1, a2, a3,
                         input logic [DW-1:0] e1, e2, e3);
    n_cmp++;
    if ({a1, a2, a3} !== {e1, e2, e3}) begin
      n_bad++;
      $display("FAIL %s: got %h/%h/%h want %h/%h/%h", name, a1, a2, a3, e1, e2, e3);
    end
  endtask

  task automatic push_win(input logic [DW-1:0] a, b, c);
    win_t w;
    w.r1 = a;
    w.r2 = b;
    w.r3 = c;
    exp_q.push_back(w);
  endtask

  // Called at negedge+0 or +2; returns on the negedge following the accepting posedge.
  task automatic wait_acc(input string name);
    bit acc;
    int n;
    n = 0;
    do begin
      #1;
      acc = rd_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no accept within 50 cycles", name);
    end
  endtask

  task automatic feed(input logic [DW-1:0] d, input string name);
    rd_data  = d;
    rd_valid = 1'b1;
    wait_acc(name);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (done !== 1'b1 && n < 20);
    chk_bit(name, done, 1'b1);
  endtask

  // Monitor samples just before the rising edge, after all stimulus for the cycle is settled.
  always @(negedge clk) begin
    #4;
    if (rd_valid && rd_ready) n_acc++;
    if (done) n_done++;
    if (hold_prev && valid) begin
      n_cmp++;
      if ({row1, row2, row3} !== held) begin
        n_bad++;
        $display("FAIL win_stable: got %h want %h", {row1, row2, row3}, held);
      end
    end
    if (valid && sacc_ready) begin
      n_cons++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL win_unexpected: got %h/%h/%h want none", row1, row2, row3);
      end else begin
        mon_e = exp_q.pop_front();
        if ({row1, row2, row3} !== {mon_e.r1, mon_e.r2, mon_e.r3}) begin
          n_bad++;
          $display("FAIL win_data: got %h/%h/%h want %h/%h/%h",
                   row1, row2, row3, mon_e.r1, mon_e.r2, mon_e.r3);
        end
      end
    end
    hold_prev = valid && !sacc_ready;
    held      = {row1, row2, row3};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[6];
    logic [DW-1:0] brow[3];
    int k;
    pat  = '{1, 0, 0, 1, 0, 1};
    brow = '{rw(8'h99), rw(8'haa), rw(8'hbb)};

    reset = 1'b1; start = 1'b0; rd_valid = 1'b0; sacc_ready = 1'b0; rd_data = '0;
    repeat (2) begin
      @(negedge clk);
      start      = 1'b1;
      rd_valid   = 1'($urandom % 2);
      sacc_ready = 1'($urandom % 2);
      rd_data    = DW'({$urandom, $urandom});
    end
    #2;
    chk_bit("reset_valid", valid, 1'b0);
    chk_bit("reset_ready", rd_ready, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_win("reset_rows", row1, row2, row3, '0, '0, '0);

    // Basic strip A..D with continuous handshakes
    @(negedge clk);
    reset = 1'b0; start = 1'b1; rd_valid = 1'b0; sacc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk_bit("start_after_reset", rd_ready, 1'b1);
    push_win(rw(8'h11), rw(8'h22), rw(8'h33));
    push_win(rw(8'h22), rw(8'h33), rw(8'h44));
    feed(rw(8'h11), "acc_a");
    feed(rw(8'h22), "acc_b");
    #2;
    chk_bit("basic_valid_early", valid, 1'b0);
    feed(rw(8'h33), "acc_c");
    #2;
    chk_bit("basic_first_valid", valid, 1'b1);
    chk_win("basic_win0", row1, row2, row3, rw(8'h11), rw(8'h22), rw(8'h33));
    feed(rw(8'h44), "acc_d");
    rd_valid = 1'b0;
    #2;
    chk_bit("basic_ready_after_last", rd_ready, 1'b0);
    chk_win("basic_win1", row1, row2, row3, rw(8'h22), rw(8'h33), rw(8'h44));
    @(negedge clk);
    #2;
    chk_bit("basic_done", done, 1'b1);
    chk_bit("basic_done_valid", valid, 1'b0);
    @(negedge clk);
    #2;
    chk_bit("basic_done_single", done, 1'b0);
    chk_int("basic_accepts", n_acc, 4);
    chk_int("basic_consumes", n_cons, 2);

    // Backpressure: sacc ready low for 6 cycles in HOLD
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; sacc_ready = 1'b0;
    push_win(rw(8'h55), rw(8'h66), rw(8'h77));
    push_win(rw(8'h66), rw(8'h77), rw(8'h88));
    feed(rw(8'h55), "acc_e");
    feed(rw(8'h66), "acc_f");
    feed(rw(8'h77), "acc_g");
    rd_data = rw(8'h88);
    for (int i = 0; i < 6; i++) begin
      #2;
      chk_bit("bp_ready", rd_ready, 1'b0);
      chk_bit("bp_valid", valid, 1'b1);
      @(negedge clk);
    end
    sacc_ready = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    #2;
    chk_win("bp_advance", row1, row2, row3, rw(8'h66), rw(8'h77), rw(8'h88));
    @(negedge clk);
    #2;
    chk_bit("bp_done", done, 1'b1);

    // Source bubbles 1,0,0,1,0,1
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_win(rw(8'h99), rw(8'haa), rw(8'hbb));
    push_win(rw(8'haa), rw(8'hbb), rw(8'hcc));
    k = 0;
    for (int i = 0; i < 6; i++) begin
      rd_valid = pat[i][0];
      if (pat[i] != 0) begin
        rd_data = brow[k];
        k++;
      end
      #2;
      chk_bit("bubble_valid_early", valid, 1'b0);
      @(negedge clk);
    end
    rd_valid = 1'b0;
    #2;
    chk_bit("bubble_first_valid", valid, 1'b1);
    chk_win("bubble_win0", row1, row2, row3, rw(8'h99), rw(8'haa), rw(8'hbb));
    feed(rw(8'hcc), "acc_l");
    rd_valid = 1'b0;
    wait_done("bubble_done");

    // Reset in HOLD after the first window
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; sacc_ready = 1'b0;
    feed(rw(8'hd1), "acc_m");
    feed(rw(8'hd2), "acc_n");
    feed(rw(8'hd3), "acc_o");
    rd_valid = 1'b0;
    #2;
    chk_bit("mid_valid", valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk_bit("mid_reset_valid", valid, 1'b0);
    chk_bit("mid_reset_ready", rd_ready, 1'b0);
    chk_bit("mid_reset_done", done, 1'b0);
    chk_win("mid_reset_rows", row1, row2, row3, '0, '0, '0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; sacc_ready = 1'b1;
    push_win(rw(8'he1), rw(8'he2), rw(8'he3));
    push_win(rw(8'he2), rw(8'he3), rw(8'he4));
    feed(rw(8'he1), "acc_p");
    feed(rw(8'he2), "acc_q");
    #2;
    chk_bit("fresh_after_reset", valid, 1'b0);
    feed(rw(8'he3), "acc_r");
    feed(rw(8'he4), "acc_s");
    rd_valid = 1'b0;
    wait_done("fresh_done");

    // Start pulses in FILL, HOLD and DONE are ignored; back-to-back strip follows
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; sacc_ready = 1'b0;
    push_win(rw(8'hf1), rw(8'hf2), rw(8'hf3));
    push_win(rw(8'hf2), rw(8'hf3), rw(8'hf4));
    feed(rw(8'hf1), "acc_t");
    start = 1'b1;
    feed(rw(8'hf2), "acc_u");
    start = 1'b0;
    feed(rw(8'hf3), "acc_v");
    rd_valid = 1'b0;
    #2;
    chk_bit("start_in_fill_ignored", valid, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk_win("start_in_hold_ignored", row1, row2, row3, rw(8'hf1), rw(8'hf2), rw(8'hf3));
    sacc_ready = 1'b1;
    feed(rw(8'hf4), "acc_w");
    rd_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    #2;
    chk_bit("busy_done", done, 1'b1);
    @(negedge clk);
    #2;
    chk_bit("start_in_done_ignored", rd_ready, 1'b0);
    @(negedge clk);
    start = 1'b0;
    push_win(rw(8'h01), rw(8'h02), rw(8'h03));
    push_win(rw(8'h02), rw(8'h03), rw(8'h04));
    feed(rw(8'h01), "acc_x");
    feed(rw(8'h02), "acc_y");
    #2;
    chk_bit("b2b_no_stale", valid, 1'b0);
    feed(rw(8'h03), "acc_z");
    feed(rw(8'h04), "acc_z4");
    rd_valid = 1'b0;
    wait_done("b2b_done");

    @(negedge clk);
    #2;
    chk_int("queue_empty", exp_q.size(), 0);
    chk_int("total_accepts", n_acc, 27);
    chk_int("total_consumes", n_cons, 12);
    chk_int("total_done_pulses", n_done, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
